// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder_behavioral ripple adder and its
// optional output register stage.
package full_adder_pkg;

  localparam int FA_MIN_WIDTH = 1;

  // Single-bit part of a registered adder result; the WIDTH-bit sum travels
  // beside it because a package type cannot follow the adder's WIDTH.
  typedef struct packed {
    logic cout;
    logic ovf;
  } fa_flags_t;

  function automatic logic fa_overflow(input logic carry_into_msb,
                                       input logic carry_out_of_msb);
    return carry_into_msb ^ carry_out_of_msb;
  endfunction

endpackage

// File: rtl/full_adder_behavioral_fa_cell.sv
// One-bit full adder: the repeated cell of the full_adder_behavioral ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_behavioral.sv
// Parameterizable ripple-carry full adder with combinational sum/cout and an
// optional registered result, built only when FULL_ADDER_REG_OUT_EN is defined.
module full_adder_behavioral
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  if (WIDTH < FA_MIN_WIDTH) begin : g_bad_width
    $error("full_adder_behavioral: WIDTH must be at least 1");
  end

  // carry[i] is the carry into bit i; carry[0] is cin.
  logic [WIDTH:0] carry;
  logic           ovf;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  assign ovf  = fa_overflow(carry[WIDTH-1], carry[WIDTH]);

`ifdef FULL_ADDER_REG_OUT_EN
  logic [WIDTH-1:0] sum_d;
  fa_flags_t        flags_d;
  fa_flags_t        flags_q;

  always_comb begin
    // NOTE: hold values are assigned first so every path drives sum_d and
    // flags_d; a missing default here would infer a latch.
    sum_d   = sum_q;
    flags_d = flags_q;
    if (en) begin
      sum_d        = sum;
      flags_d.cout = cout;
      flags_d.ovf  = ovf;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign cout_q = flags_q.cout;
  assign ovf_q  = flags_q.ovf;
`else
  assign sum_q  = '0;
  assign cout_q = 1'b0;
  assign ovf_q  = 1'b0;

  // The register controls and the overflow tap have no load in this build.
  logic unused_reg_ctrl;
  assign unused_reg_ctrl = ^{clk, rst_n, en, ovf};
`endif

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Self-checking bench for full_adder_behavioral at WIDTH=1 and WIDTH=4; covers
// both the registered and the constant-zero register builds.
module tb_full_adder_behavioral;

`ifdef FULL_ADDER_REG_OUT_EN
  localparam bit REG_BUILD = 1'b1;
`else
  localparam bit REG_BUILD = 1'b0;
`endif

  typedef struct {
    int unsigned s;
    bit          co;
    bit          ov;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;

  logic [0:0] a1, b1, sum1, sum_q1;
  logic       cin1, cout1, cout_q1, ovf_q1;
  logic [3:0] a4, b4, sum4, sum_q4;
  logic       cin4, cout4, cout_q4, ovf_q4;

  int checks   = 0;
  int failures = 0;

  // Expected registered outputs, maintained by the reference model below.
  res_t exp_q1, exp_q4;

  always #5 clk = ~clk;

  full_adder_behavioral #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .ovf_q(ovf_q1)
  );

  full_adder_behavioral #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4), .ovf_q(ovf_q4)
  );

  // Reference: plain integer arithmetic, unsigned for sum/cout and signed
  // range test for overflow.
  function automatic res_t ref_add(input int w, input int unsigned a,
                                   input int unsigned b, input int unsigned c);
    res_t        r;
    int unsigned total;
    int          sa, sb, st;
    total = a + b + c;
    r.s   = total % (32'd1 << w);
    r.co  = ((total >> w) & 1) != 0;
    sa    = (a >= (32'd1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb    = (b >= (32'd1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    st    = sa + sb + int'(c);
    r.ov  = (st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1)));
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q1 = '{0, 1'b0, 1'b0};
      exp_q4 = '{0, 1'b0, 1'b0};
    end else if (REG_BUILD && en) begin
      exp_q1 = ref_add(1, a1, b1, cin1);
      exp_q4 = ref_add(4, a4, b4, cin4);
    end
  end

  task automatic drive_random();
    a1   = 1'($urandom);
    b1   = 1'($urandom);
    cin1 = 1'($urandom);
    a4   = 4'($urandom);
    b4   = 4'($urandom);
    cin4 = 1'($urandom);
  endtask

  task automatic test_reset();
    res_t r;
    rst_n = 1'b0;
    en    = 1'b1;
    drive_random();
    #2;
    checks++;
    if ({sum_q4, cout_q4, ovf_q4} !== 6'b0) begin
      failures++;
      $display("FAIL reset_regs_w4 got sum_q=%h cout_q=%b ovf_q=%b want all 0", sum_q4, cout_q4, ovf_q4);
    end
    checks++;
    if ({sum_q1, cout_q1, ovf_q1} !== 3'b0) begin
      failures++;
      $display("FAIL reset_regs_w1 got %b%b%b want 000", sum_q1, cout_q1, ovf_q1);
    end
    r = ref_add(4, a4, b4, cin4);
    checks++;
    if ({cout4, sum4} !== {r.co, 4'(r.s)}) begin
      failures++;
      $display("FAIL reset_comb_w4 got %b_%h want %b_%h", cout4, sum4, r.co, 4'(r.s));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    res_t r;
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      #100;
      r = ref_add(1, a1, b1, cin1);
      checks++;
      if ({cout1, sum1} !== {r.co, 1'(r.s)}) begin
        failures++;
        $display("FAIL truth_table abc=%03b got %b%b want %b%b", 3'(i), cout1, sum1, r.co, 1'(r.s));
      end
    end
  endtask

  task automatic test_exhaustive();
    res_t r;
    for (int i = 0; i < 512; i++) begin
      a4   = 4'(i >> 5);
      b4   = 4'(i >> 1);
      cin4 = 1'(i);
      #1;
      r = ref_add(4, a4, b4, cin4);
      checks++;
      if ({cout4, sum4} !== {r.co, 4'(r.s)}) begin
        failures++;
        $display("FAIL exhaustive a=%h b=%h cin=%b got %b_%h want %b_%h", a4, b4, cin4, cout4, sum4, r.co, 4'(r.s));
      end
    end
  endtask

  task automatic test_directed();
    @(negedge clk);
    en = 1'b1;
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #1;
    checks++;
    if ({cout4, sum4} !== 5'b1_0000) begin
      failures++;
      $display("FAIL wrap_F_0_1 got %b_%h want 1_0", cout4, sum4);
    end
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    #1;
    checks++;
    if ({cout4, sum4} !== 5'b0_1000) begin
      failures++;
      $display("FAIL signed_ovf_comb got %b_%h want 0_8", cout4, sum4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ovf_q4 !== REG_BUILD) begin
      failures++;
      $display("FAIL signed_ovf_reg got ovf_q=%b want %b", ovf_q4, REG_BUILD);
    end
    checks++;
    if (sum_q4 !== (REG_BUILD ? 4'h8 : 4'h0)) begin
      failures++;
      $display("FAIL signed_ovf_sum_q got %h want %h", sum_q4, REG_BUILD ? 4'h8 : 4'h0);
    end
  endtask

  // Inputs change mid-cycle: registers must keep the old value until the
  // next rising edge, then show the pre-edge combinational result.
  task automatic test_capture();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_random();
      #1;
      checks++;
      if ({sum_q4, cout_q4, ovf_q4} !== {4'(exp_q4.s), exp_q4.co, exp_q4.ov}) begin
        failures++;
        $display("FAIL capture_early it=%0d got %h%b%b want %h%b%b", i, sum_q4, cout_q4, ovf_q4, 4'(exp_q4.s), exp_q4.co, exp_q4.ov);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({sum_q4, cout_q4, ovf_q4} !== {4'(exp_q4.s), exp_q4.co, exp_q4.ov}) begin
        failures++;
        $display("FAIL capture_edge it=%0d got %h%b%b want %h%b%b", i, sum_q4, cout_q4, ovf_q4, 4'(exp_q4.s), exp_q4.co, exp_q4.ov);
      end
      checks++;
      if ({sum_q1, cout_q1, ovf_q1} !== {1'(exp_q1.s), exp_q1.co, exp_q1.ov}) begin
        failures++;
        $display("FAIL capture_w1 it=%0d got %b%b%b want %b%b%b", i, sum_q1, cout_q1, ovf_q1, 1'(exp_q1.s), exp_q1.co, exp_q1.ov);
      end
    end
  endtask

  task automatic test_hold();
    res_t r;
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_random();
      @(posedge clk);
      #1;
      r = ref_add(4, a4, b4, cin4);
      checks++;
      if ({sum_q4, cout_q4, ovf_q4} !== (REG_BUILD ? 6'b0011_1_1 : 6'b0)) begin
        failures++;
        $display("FAIL hold it=%0d got %h%b%b want %h", i, sum_q4, cout_q4, ovf_q4, REG_BUILD ? 6'b0011_1_1 : 6'b0);
      end
      checks++;
      if ({cout4, sum4} !== {r.co, 4'(r.s)}) begin
        failures++;
        $display("FAIL hold_comb it=%0d got %b_%h want %b_%h", i, cout4, sum4, r.co, 4'(r.s));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    en = 1'b1;
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_q4, cout_q4, ovf_q4} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_regs got %h%b%b want 0", sum_q4, cout_q4, ovf_q4);
    end
    for (int i = 0; i < 4; i++) begin
      drive_random();
      #3;
      r = ref_add(4, a4, b4, cin4);
      checks++;
      if ({cout4, sum4} !== {r.co, 4'(r.s)}) begin
        failures++;
        $display("FAIL reset_mid_comb it=%0d got %b_%h want %b_%h", i, cout4, sum4, r.co, 4'(r.s));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q4, cout_q4, ovf_q4} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_hold got %h%b%b want 0", sum_q4, cout_q4, ovf_q4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a4 = 4'hC; b4 = 4'h5; cin4 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q4, cout_q4, ovf_q4} !== (REG_BUILD ? 6'b0010_1_0 : 6'b0)) begin
      failures++;
      $display("FAIL reset_release got %h%b%b want %h", sum_q4, cout_q4, ovf_q4, REG_BUILD ? 6'b0010_1_0 : 6'b0);
    end
  endtask

  // Random enable and input changes every cycle, including reset pulses.
  task automatic test_back_to_back();
    res_t r;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en = 1'($urandom);
      drive_random();
      if (i % 13 == 7) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      r = ref_add(4, a4, b4, cin4);
      checks++;
      if ({sum_q4, cout_q4, ovf_q4} !== {4'(exp_q4.s), exp_q4.co, exp_q4.ov}) begin
        failures++;
        $display("FAIL b2b_reg it=%0d got %h%b%b want %h%b%b", i, sum_q4, cout_q4, ovf_q4, 4'(exp_q4.s), exp_q4.co, exp_q4.ov);
      end
      checks++;
      if ({cout4, sum4} !== {r.co, 4'(r.s)}) begin
        failures++;
        $display("FAIL b2b_comb it=%0d got %b_%h want %b_%h", i, cout4, sum4, r.co, 4'(r.s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_exhaustive();
    test_directed();
    test_capture();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
